// File: rtl/cbus_arbiter_n_pkg.sv
// Shared CBus transaction types plus the arbiter's state encoding and index-width helper.
package cbus_arbiter_n_pkg;

  localparam int CBUS_AW = 32;
  localparam int CBUS_DW = 32;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [CBUS_AW-1:0] addr;
    logic [CBUS_DW-1:0] wdata;
    logic [3:0]         len;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] rdata;
  } cbus_resp_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // A single port still needs a one-bit index.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_n_rr_pick.sv
// Combinational winner picker: forced ports win lowest-index first, otherwise a
// circular scan from start.
module cbus_arbiter_n_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     force_vec,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  logic [N-1:0] fv;
  logic         found;
  int           j;

  always_comb begin
    idx       = '0;
    found     = 1'b0;
    j         = 0;
    fv        = force_vec & valid;
    any_valid = |valid;
    if (|fv) begin
      for (int i = N - 1; i >= 0; i--)
        if (fv[i]) idx = IDX_W'(i);
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (int'(start) + k) % N;
        if (!found && valid[j]) begin
          idx   = IDX_W'(j);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter_n.sv
// N-to-1 CBus arbiter: round-robin or fixed priority with starvation promotion.
// The grant is registered on IDLE->BUSY and held until the last beat is accepted.
module cbus_arbiter_n
  import cbus_arbiter_n_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 4,
  localparam int IDX_W       = calc_idx_w(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cbus_req_t  [NUM_PORTS-1:0]  ireqs,
  output cbus_resp_t [NUM_PORTS-1:0]  iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        busy
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  arb_state_t                         state;
  logic [IDX_W-1:0]                   sel;
  logic [IDX_W-1:0]                   rr_ptr;
  logic [NUM_PORTS-1:0][CNT_W-1:0]    starve_cnt;

  logic [NUM_PORTS-1:0] valid_vec;
  logic [NUM_PORTS-1:0] force_vec;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     pick_idx;
  logic                 any_valid;
  logic                 done;
  logic [IDX_W-1:0]     next_ptr;

  always_comb begin
    valid_vec = '0;
    force_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid_vec[i] = ireqs[i].valid;
      force_vec[i] = (RR_MODE == 0) && (STARVE_LIMIT != 0) &&
                     (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  assign start = (RR_MODE != 0) ? rr_ptr : '0;

  cbus_arbiter_n_rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid     (valid_vec),
    .start     (start),
    .force_vec (force_vec),
    .idx       (pick_idx),
    .any_valid (any_valid)
  );

  assign done     = (state == ARB_BUSY) && oresp.ready && oresp.last;
  assign next_ptr = (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      sel        <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (any_valid) begin
          sel   <= pick_idx;
          state <= ARB_BUSY;
          // Losers that were waiting age by one, saturating at the limit.
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (IDX_W'(i) == pick_idx)
              starve_cnt[i] <= '0;
            else if (valid_vec[i] && starve_cnt[i] != CNT_W'(STARVE_LIMIT))
              starve_cnt[i] <= starve_cnt[i] + 1'b1;
          end
        end
        ARB_BUSY: if (done) begin
          state  <= ARB_IDLE;
          rr_ptr <= next_ptr;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Request and response are pure pass-through while owned; valid drops propagate as-is.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state == ARB_BUSY) begin
      oreq        = ireqs[sel];
      iresps[sel] = oresp;
    end
  end

  assign busy      = (state == ARB_BUSY);
  assign grant_idx = sel;

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Directed bench: a 4-port round-robin instance and a 2-port fixed-priority instance.
module tb_cbus_arbiter_n;
  import cbus_arbiter_n_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_req_t  [3:0] rr_ireqs;
  cbus_resp_t [3:0] rr_iresps;
  cbus_req_t        rr_oreq;
  cbus_resp_t       rr_oresp;
  logic [1:0]       rr_grant;
  logic             rr_busy;

  cbus_req_t  [1:0] fp_ireqs;
  cbus_resp_t [1:0] fp_iresps;
  cbus_req_t        fp_oreq;
  cbus_resp_t       fp_oresp;
  logic [0:0]       fp_grant;
  logic             fp_busy;

  cbus_arbiter_n #(.NUM_PORTS(4), .RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .reset(reset), .ireqs(rr_ireqs), .iresps(rr_iresps),
    .oreq(rr_oreq), .oresp(rr_oresp), .grant_idx(rr_grant), .busy(rr_busy)
  );

  cbus_arbiter_n #(.NUM_PORTS(2), .RR_MODE(0), .STARVE_LIMIT(2)) u_fp (
    .clk(clk), .reset(reset), .ireqs(fp_ireqs), .iresps(fp_iresps),
    .oreq(fp_oreq), .oresp(fp_oresp), .grant_idx(fp_grant), .busy(fp_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mk_req(input logic [31:0] a);
    cbus_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.addr  = a;
    r.len   = 4'd3;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.rdata = d;
    return r;
  endfunction

  function automatic logic [31:0] port_addr(input int p);
    return 32'h8000_0000 + 32'(p) * 32'h100;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int exp_g[6]  = '{0, 0, 1, 0, 0, 1};
    int exp_c1[6] = '{1, 2, 0, 1, 2, 0};

    reset = 1'b1;
    rr_ireqs = '0; fp_ireqs = '0; rr_oresp = '0; fp_oresp = '0;
    tick(); tick();
    chk("rst_rr_busy", rr_busy, 0);
    chk("rst_rr_oreq", rr_oreq, '0);
    chk("rst_rr_grant", rr_grant, 0);
    chk("rst_fp_iresps", fp_iresps, '0);
    chk("rst_fp_busy", fp_busy, 0);

    // Single port: 4-beat read from port 1
    tick();
    reset = 1'b0;
    fp_ireqs[1] = mk_req(32'h8000_0000);
    #1;
    chk("t1_no_comb_grant", fp_oreq.valid, 0);
    chk("t1_idle_busy", fp_busy, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      fp_oresp = mk_resp(1'b1, b == 3, 32'hd000 + 32'(b));
      #1;
      chk("t1_oreq_valid", fp_oreq.valid, 1);
      chk("t1_oreq_addr", fp_oreq.addr, 32'h8000_0000);
      chk("t1_grant", fp_grant, 1);
      chk("t1_resp1", fp_iresps[1], mk_resp(1'b1, b == 3, 32'hd000 + 32'(b)));
      chk("t1_resp0", fp_iresps[0], '0);
    end
    tick();
    fp_ireqs = '0; fp_oresp = '0;
    #1;
    chk("t1_busy_low", fp_busy, 0);
    chk("t1_oreq_zero", fp_oreq, '0);

    // Round-robin: all four ports valid, single-beat transactions
    for (int i = 0; i < 4; i++) rr_ireqs[i] = mk_req(port_addr(i));
    rr_oresp = mk_resp(1'b1, 1'b1, 32'h0);
    #1;
    chk("t2_start_idle", rr_busy, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2_busy", rr_busy, 1);
      chk("t2_grant", rr_grant, k % 4);
      chk("t2_addr", rr_oreq.addr, port_addr(k % 4));
      tick();
      chk("t2_gap", rr_busy, 0);
      chk("t2_gap_valid", rr_oreq.valid, 0);
    end
    rr_ireqs = '0;

    // Fixed priority with promotion (limit 2)
    fp_ireqs[0] = mk_req(port_addr(0));
    fp_ireqs[1] = mk_req(port_addr(1));
    fp_oresp = mk_resp(1'b1, 1'b1, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t3_grant", fp_grant, exp_g[k]);
      chk("t3_cnt1", u_fp.starve_cnt[1], exp_c1[k]);
      tick();
      chk("t3_gap", fp_busy, 0);
    end
    fp_ireqs = '0; fp_oresp = '0;

    // Burst hold: port 0 8-beat burst, ready toggling, port 1 arrives mid-burst
    rr_ireqs[0] = mk_req(port_addr(0));
    rr_oresp = '0;
    tick();
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      if (beats >= 2) rr_ireqs[1] = mk_req(port_addr(1));
      rr_oresp = mk_resp(c % 2 == 0, (c % 2 == 0) && beats == 7, 32'hb0 + 32'(beats));
      #1;
      chk("t4_busy", rr_busy, 1);
      chk("t4_grant", rr_grant, 0);
      chk("t4_addr", rr_oreq.addr, port_addr(0));
      if (c % 2 == 0) beats++;
      tick();
    end
    chk("t4_beats", beats, 8);
    rr_ireqs[0] = '0; rr_oresp = '0;
    #1;
    chk("t4_gap", rr_busy, 0);
    tick();
    chk("t4_next_busy", rr_busy, 1);
    chk("t4_next_grant", rr_grant, 1);
    chk("t4_next_addr", rr_oreq.addr, port_addr(1));
    rr_oresp = mk_resp(1'b1, 1'b1, 32'h0);
    tick();
    rr_ireqs = '0; rr_oresp = '0;
    #1;
    chk("t4_end_idle", rr_busy, 0);

    // Reset mid-burst on the fixed-priority instance
    fp_ireqs[0] = mk_req(port_addr(0));
    fp_ireqs[1] = mk_req(port_addr(1));
    tick();
    fp_oresp = mk_resp(1'b1, 1'b0, 32'h1);
    #1;
    chk("t5_beat1_busy", fp_busy, 1);
    chk("t5_beat1_grant", fp_grant, 0);
    tick();
    reset = 1'b1;
    fp_oresp = mk_resp(1'b1, 1'b0, 32'h2);
    #1;
    chk("t5_beat2_valid", fp_oreq.valid, 1);
    tick();
    chk("t5_rst_busy", fp_busy, 0);
    chk("t5_rst_oreq", fp_oreq, '0);
    chk("t5_rst_grant", fp_grant, 0);
    chk("t5_rst_cnt", u_fp.starve_cnt, 0);
    chk("t5_rst_rrptr", u_rr.rr_ptr, 0);
    reset = 1'b0;
    fp_ireqs[0] = '0;
    fp_oresp = '0;
    for (int i = 0; i < 4; i++) rr_ireqs[i] = mk_req(port_addr(i));
    #1;
    chk("t5_post_idle", fp_busy, 0);
    tick();
    chk("t5_fresh_busy", fp_busy, 1);
    chk("t5_fresh_grant", fp_grant, 1);
    chk("t5_fresh_addr", fp_oreq.addr, port_addr(1));
    chk("t5_rr_grant0", rr_grant, 0);
    fp_oresp = mk_resp(1'b1, 1'b1, 32'h0);
    rr_oresp = mk_resp(1'b1, 1'b1, 32'h0);
    tick();
    fp_ireqs = '0; fp_oresp = '0;
    rr_ireqs = '0; rr_oresp = '0;
    #1;
    chk("t5_end_idle", fp_busy, 0);
    chk("t5_rr_end_idle", rr_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
